huff_bit_packer: RTL and testbench

- Parametrised successor to the fixed 8-bit/32-bit Huffman coder.
- Accepts variable-length codewords of up to CODE_W bits and packs them MSB-first into OUT_W-bit words.
- Adds an input ready signal and output backpressure (out_ready).
- finalize flushes the last partial word, zero-padded, and reports its valid-bit count.
- Sits between the Huffman code-table lookup and the output word FIFO/UART.

---
 rtl/huff_bit_packer.sv | 143 ++++++++++++++
 tb/tb_huff_bit_packer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_bit_packer.sv
// huff_bit_packer: packs variable-length, right-aligned codewords MSB-first into OUT_W-bit words.
// A finalize pulse flushes the trailing partial word (zero-padded) and ends with a done pulse.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   ce, code, length codeword input; accepted when ce && in_ready; length 0 is a no-op
//   in_ready         packer can accept a codeword this cycle
//   finalize         single-cycle flush request (ignored while a flush is in progress)
//   encoded_out      packed word, first-received bit at the MSB
//   length_out       valid bits in encoded_out (OUT_W for full words)
//   enable_out       output valid; held stable until out_ready
//   out_ready        downstream consumes the word when enable_out && out_ready
//   done             one-cycle pulse when a flush completes
//
// Optional feature macro HUFF_PACK_STATS_EN adds total_bits[31:0] (accepted bits) and
// total_words[15:0] (consumed words) counters.

module huff_bit_packer #(
  parameter int unsigned CODE_W = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned LEN_W  = $clog2(CODE_W + 1),
  parameter int unsigned LO_W   = $clog2(OUT_W + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  length,
  input  logic              finalize,
  output logic [OUT_W-1:0]  encoded_out,
  output logic              enable_out,
  input  logic              out_ready,
  output logic [LO_W-1:0]   length_out,
  output logic              done
`ifdef HUFF_PACK_STATS_EN
  ,
  output logic [31:0]       total_bits,
  output logic [15:0]       total_words
`endif
);

  localparam int unsigned AW = OUT_W + CODE_W;
  localparam int unsigned FW = $clog2(AW + 1);

  typedef enum logic [1:0] {StIdle, StDrain, StTail, StDone} flush_e;

  flush_e            r_state, w_state_nxt;
  logic [AW-1:0]     r_acc;
  logic [FW-1:0]     r_fill;
  logic [OUT_W-1:0]  r_out;
  logic              r_en;
  logic [LO_W-1:0]   r_len;

  logic              w_full, w_free, w_accept, w_emit_word, w_tail;
  logic [LEN_W-1:0]  w_eff;
  logic [CODE_W-1:0] w_mask;
  logic [AW-1:0]     w_ins;

  assign w_full      = r_fill >= FW'(OUT_W);
  assign w_free      = !r_en || out_ready;
  assign in_ready    = !w_full && (r_state == StIdle);
  assign w_accept    = ce && in_ready;
  assign w_eff       = (length > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : length;
  // Shifting all-ones left by CODE_W yields zero, so a full-width codeword keeps every bit.
  assign w_mask      = ~({CODE_W{1'b1}} << w_eff);
  // Place the codeword directly below the bits already held (accumulator is left-aligned).
  assign w_ins       = {{OUT_W{1'b0}}, code & w_mask} << (FW'(AW) - r_fill - FW'(w_eff));
  assign w_emit_word = w_full && w_free;
  // TAIL is only entered with fill < OUT_W and no accepts possible, so no full word competes.
  assign w_tail      = (r_state == StTail) && w_free;

  // Flush sequencing
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (finalize) w_state_nxt = StDrain;
      StDrain: if (!w_full) w_state_nxt = StTail;
      StTail:  if (w_free) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Accumulator and output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_fill <= '0;
      r_out  <= '0;
      r_en   <= 1'b0;
      r_len  <= '0;
    end else if (w_emit_word) begin
      r_out  <= r_acc[AW-1 -: OUT_W];
      r_len  <= LO_W'(OUT_W);
      r_en   <= 1'b1;
      r_acc  <= r_acc << OUT_W;
      r_fill <= r_fill - FW'(OUT_W);
    end else if (w_tail && (r_fill != '0)) begin
      // Bits below fill are already zero, giving the zero padding for free.
      r_out  <= r_acc[AW-1 -: OUT_W];
      r_len  <= LO_W'(r_fill);
      r_en   <= 1'b1;
      r_acc  <= '0;
      r_fill <= '0;
    end else begin
      if (out_ready) r_en <= 1'b0;
      if (w_accept) begin
        r_acc  <= r_acc | w_ins;
        r_fill <= r_fill + FW'(w_eff);
      end
    end
  end

  assign encoded_out = r_out;
  assign enable_out  = r_en;
  assign length_out  = r_len;
  assign done        = (r_state == StDone);

`ifdef HUFF_PACK_STATS_EN
  logic [31:0] r_total_bits;
  logic [15:0] r_total_words;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_total_bits  <= '0;
      r_total_words <= '0;
    end else begin
      if (w_accept)            r_total_bits  <= r_total_bits + 32'(w_eff);
      if (r_en && out_ready)   r_total_words <= r_total_words + 16'd1;
    end
  end

  assign total_bits  = r_total_bits;
  assign total_words = r_total_words;
`endif

endmodule

// File: tb/tb_huff_bit_packer.sv
// Self-checking bench for huff_bit_packer: directed scenarios followed by randomized traffic,
// all checked against a bit-queue reference model.

module tb_huff_bit_packer;

  localparam int unsigned CODE_W = 16;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned LEN_W  = $clog2(CODE_W + 1);
  localparam int unsigned LO_W   = $clog2(OUT_W + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ce = 1'b0;
  logic              in_ready;
  logic [CODE_W-1:0] code = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              finalize = 1'b0;
  logic [OUT_W-1:0]  encoded_out;
  logic              enable_out;
  logic              out_ready = 1'b1;
  logic [LO_W-1:0]   length_out;
  logic              done;
`ifdef HUFF_PACK_STATS_EN
  logic [31:0]       total_bits;
  logic [15:0]       total_words;
`endif

  huff_bit_packer #(.CODE_W(CODE_W), .OUT_W(OUT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .ce          (ce),
    .in_ready    (in_ready),
    .code        (code),
    .length      (length),
    .finalize    (finalize),
    .encoded_out (encoded_out),
    .enable_out  (enable_out),
    .out_ready   (out_ready),
    .length_out  (length_out),
    .done        (done)
`ifdef HUFF_PACK_STATS_EN
    ,
    .total_bits  (total_bits),
    .total_words (total_words)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: pending bit stream plus expected output words.
  bit               bitq[$];
  logic [OUT_W-1:0] expw[$];
  int               expl[$];
  bit               pend = 0;
  int               flushes = 0;
  int               dones = 0;
  int               words_seen = 0;
  int               en_cycles = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [CODE_W-1:0] cd, input logic [LEN_W-1:0] ln);
    int eff;
    logic [OUT_W-1:0] w;
    eff = (int'(ln) > CODE_W) ? CODE_W : int'(ln);
    for (int i = eff - 1; i >= 0; i--) bitq.push_back(cd[i]);
    while (bitq.size() >= OUT_W) begin
      w = '0;
      for (int j = 0; j < OUT_W; j++) w = {w[OUT_W-2:0], bitq.pop_front()};
      expw.push_back(w);
      expl.push_back(OUT_W);
    end
  endtask

  task automatic model_flush();
    int n;
    logic [OUT_W-1:0] w;
    n = bitq.size();
    if (n > 0) begin
      w = '0;
      for (int j = 0; j < OUT_W; j++) begin
        w = w << 1;
        if (j < n) w[0] = bitq[j];
      end
      bitq.delete();
      expw.push_back(w);
      expl.push_back(n);
    end
    flushes++;
  endtask

  // Output monitor, sampled mid-cycle.
  logic             hold_prev = 0;
  logic [OUT_W-1:0] prev_data;
  logic [LO_W-1:0]  prev_len;
  logic             prev_done = 0;

  always @(negedge clock) begin
    if (reset) begin
      hold_prev = 0;
      prev_done = 0;
    end else begin
      if (enable_out) en_cycles++;
      if (hold_prev) begin
        chk("hold_enable", enable_out, 1);
        chk("hold_data", encoded_out, prev_data);
        chk("hold_len", length_out, prev_len);
      end
      hold_prev = enable_out && !out_ready;
      prev_data = encoded_out;
      prev_len  = length_out;
      if (enable_out && out_ready) begin
        words_seen++;
        chk("word_expected", expw.size() > 0, 1);
        if (expw.size() > 0) begin
          chk("word_data", encoded_out, expw.pop_front());
          chk("word_len", length_out, expl.pop_front());
        end
      end
      if (done) begin
        dones++;
        chk("done_one_cycle", prev_done, 0);
      end
      prev_done = done;
    end
  end

  // One clock cycle: drive at posedge+1, update model for the coming edge, advance.
  task automatic cyc(input logic c, input logic [CODE_W-1:0] cd, input logic [LEN_W-1:0] ln,
                     input logic fin, input logic ordy, output logic acc);
    ce = c; code = cd; length = ln; finalize = fin; out_ready = ordy;
    if (pend) chk("in_ready_flush", in_ready, 0);
    if (done) chk("done_while_flush", pend, 1);
    acc = c && in_ready;
    if (acc) model_push(cd, ln);
    if (fin && !pend) begin
      model_flush();
      pend = 1;
    end else if (done) begin
      pend = 0;
    end
    @(posedge clock);
    #1;
    ce = 0; finalize = 0;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, ordy, a);
  endtask

  task automatic send(input logic [CODE_W-1:0] cd, input logic [LEN_W-1:0] ln, input logic ordy);
    logic a;
    a = 0;
    for (int i = 0; i < 50 && !a; i++) cyc(1, cd, ln, 0, ordy, a);
    chk("send_accepted", a, 1);
  endtask

  task automatic flush_and_wait();
    logic a;
    cyc(0, '0, '0, 1, 1, a);
    for (int i = 0; i < 60 && pend; i++) cyc(0, '0, '0, 0, 1, a);
    chk("flush_completed", pend, 0);
  endtask

  task automatic async_reset_check();
    @(posedge clock);
    #3;
    reset = 1;
    #1;
    chk("rst_encoded_out", encoded_out, 0);
    chk("rst_enable_out", enable_out, 0);
    chk("rst_length_out", length_out, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 1);
    bitq.delete(); expw.delete(); expl.delete();
    pend = 0;
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  int w0, d0, e0;
  logic a;
`ifdef HUFF_PACK_STATS_EN
  logic [31:0] tb0;
  logic [15:0] tw0;
`endif

  initial begin
    // Power-on reset
    repeat (2) @(posedge clock);
    #1;
    chk("por_encoded_out", encoded_out, 0);
    chk("por_enable_out", enable_out, 0);
    chk("por_length_out", length_out, 0);
    chk("por_done", done, 0);
    reset = 0;
    chk("por_in_ready", in_ready, 1);

    // 1: sixteen 2-bit codewords -> 0xAAAAAAAA, enable_out for one cycle, no done
    w0 = words_seen; d0 = dones; e0 = en_cycles;
    for (int i = 0; i < 16; i++) send(16'h0002, 5'd2, 1);
    idle(4, 1);
    chk("s1_words", words_seen - w0, 1);
    chk("s1_en_cycles", en_cycles - e0, 1);
    chk("s1_no_done", dones - d0, 0);

    // 2: three 12-bit 0xABC then finalize -> 0xABCABCAB, 0xC0000000/4, one done
`ifdef HUFF_PACK_STATS_EN
    tb0 = total_bits; tw0 = total_words;
`endif
    w0 = words_seen; d0 = dones;
    for (int i = 0; i < 3; i++) send(16'h0ABC, 5'd12, 1);
    flush_and_wait();
    idle(2, 1);
    chk("s2_words", words_seen - w0, 2);
    chk("s2_done", dones - d0, 1);
`ifdef HUFF_PACK_STATS_EN
    chk("s6_total_bits", total_bits - tb0, 36);
    chk("s6_total_words", total_words - tw0, 2);
`endif

    // 3: backpressure holds the word and stalls input once the accumulator is full
    send(16'hDEAD, 5'd16, 0);
    send(16'hBEEF, 5'd16, 0);
    idle(1, 0);
    send(16'h1234, 5'd16, 0);
    send(16'h5678, 5'd16, 0);
    idle(4, 0);
    chk("s3_in_ready_full", in_ready, 0);
    chk("s3_enable_held", enable_out, 1);
    idle(4, 1);
    chk("s3_drained", expw.size(), 0);

    // 4: masked 4-bit code plus zero-length no-op, then an empty flush
    w0 = words_seen; d0 = dones;
    send(16'hFFFF, 5'd4, 1);
    send(16'h1234, 5'd0, 1);
    flush_and_wait();
    idle(2, 1);
    chk("s4_words", words_seen - w0, 1);
    w0 = words_seen; e0 = en_cycles;
    flush_and_wait();
    idle(2, 1);
    chk("s4_empty_no_word", words_seen - w0, 0);
    chk("s4_empty_no_enable", en_cycles - e0, 0);
    chk("s4_dones", dones - d0, 2);

    // 5: async reset with fill=20 and a word waiting, then a fresh 2-bit flush
    send(16'hCAFE, 5'd16, 0);
    send(16'hF00D, 5'd16, 0);
    idle(1, 0);
    send(16'h0123, 5'd16, 0);
    send(16'h0009, 5'd4, 0);
    chk("s5_pre_enable", enable_out, 1);
    async_reset_check();
    w0 = words_seen;
    send(16'h0003, 5'd2, 1);
    flush_and_wait();
    idle(2, 1);
    chk("s5_words", words_seen - w0, 1);

    // Randomized traffic: random lengths (incl. > CODE_W), backpressure and finalize pulses
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, CODE_W'($urandom), LEN_W'($urandom_range(0, (1 << LEN_W) - 1)),
          $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, a);
    end
    idle(4, 1);
    flush_and_wait();
    idle(4, 1);
    chk("rand_exp_empty", expw.size(), 0);
    chk("rand_done_count", dones, flushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
